// File: rtl/multi_port_fifo_packer_pkg.sv
// Shared types and helpers for the multi-port FIFO packer.
package multi_port_fifo_packer_pkg;

  localparam int LANES      = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WIDTH  = $clog2(LANES + 1);

  typedef logic [LANES-1:0] mask_t;

  // Encoded as {skid valid, out valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } pack_state_t;

  function automatic logic [NUM_WIDTH-1:0] popcount(input mask_t m);
    logic [NUM_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + NUM_WIDTH'(m[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/multi_port_fifo_packer_lane_compactor.sv
// Combinational lane compactor: packs valid lanes into slots 0..num-1, order preserved.
module multi_port_fifo_packer_lane_compactor
  import multi_port_fifo_packer_pkg::*;
(
  input  mask_t                       mask,
  input  logic [LANES*DATA_WIDTH-1:0] data_in,
  output logic [NUM_WIDTH-1:0]        num,
  output logic [LANES*DATA_WIDTH-1:0] data_out
);

  logic [NUM_WIDTH-1:0] slot;

  always_comb begin
    data_out = '0;
    slot     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        data_out[slot*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        slot = slot + NUM_WIDTH'(1);
      end
    end
    num = popcount(mask);
  end

endmodule

// File: rtl/multi_port_fifo_packer.sv
// Packer front end: compacts sparse input packets into a registered FIFO write request
// behind a two-entry skid so in_ready_o depends only on register state.
module multi_port_fifo_packer
  import multi_port_fifo_packer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  mask_t                       in_mask_i,
  input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
  output logic                        write_valid_o,
  input  logic                        write_ready_i,
  output logic [NUM_WIDTH-1:0]        write_num_o,
  output logic [LANES*DATA_WIDTH-1:0] write_data_o,
  output logic [NUM_WIDTH:0]          pending_o
);

  logic [NUM_WIDTH-1:0]        comp_num_p0;
  logic [LANES*DATA_WIDTH-1:0] comp_data_p0;

  multi_port_fifo_packer_lane_compactor u_lane_compactor (
    .mask     (in_mask_i),
    .data_in  (in_data_i),
    .num      (comp_num_p0),
    .data_out (comp_data_p0)
  );

  pack_state_t                 state_p1, state_nxt;
  logic [NUM_WIDTH-1:0]        out_num_p1, skid_num_p1;
  logic [LANES*DATA_WIDTH-1:0] out_data_p1, skid_data_p1;
  logic                        out_vld_p1, skid_vld_p1;
  logic                        drain, acc;
  logic                        load_out_in, load_out_skid, load_skid;

  assign out_vld_p1  = state_p1[0];
  assign skid_vld_p1 = state_p1[1];
  assign in_ready_o  = ~skid_vld_p1;
  assign drain       = out_vld_p1 & write_ready_i;
  assign acc         = in_valid_i & in_ready_o & (|in_mask_i);

  always_comb begin
    state_nxt     = state_p1;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (acc) begin
          load_out_in = 1'b1;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (drain && acc) begin
          load_out_in = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end
      end
      TWO: begin
        if (drain) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0 -> p1: flush and reset both discard everything held.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      state_p1     <= EMPTY;
      out_num_p1   <= '0;
      out_data_p1  <= '0;
      skid_num_p1  <= '0;
      skid_data_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (load_out_in) begin
        out_num_p1  <= comp_num_p0;
        out_data_p1 <= comp_data_p0;
      end else if (load_out_skid) begin
        out_num_p1  <= skid_num_p1;
        out_data_p1 <= skid_data_p1;
      end
      if (load_skid) begin
        skid_num_p1  <= comp_num_p0;
        skid_data_p1 <= comp_data_p0;
      end
    end
  end

  assign write_valid_o = out_vld_p1;
  assign write_num_o   = out_num_p1;
  assign write_data_o  = out_data_p1;
  assign pending_o     = (out_vld_p1  ? {1'b0, out_num_p1}  : '0)
                       + (skid_vld_p1 ? {1'b0, skid_num_p1} : '0);

endmodule

// File: tb/tb_multi_port_fifo_packer.sv
// Scoreboard bench for multi_port_fifo_packer: directed vectors plus a random stream.
module tb_multi_port_fifo_packer;

  localparam int L  = 4;
  localparam int DW = 32;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, in_valid_i, in_ready_o;
  logic [L-1:0]  in_mask_i;
  logic [127:0]  in_data_i;
  logic          write_valid_o, write_ready_i;
  logic [NW-1:0] write_num_o;
  logic [127:0]  write_data_o;
  logic [NW:0]   pending_o;

  multi_port_fifo_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_mask_i     (in_mask_i),
    .in_data_i     (in_data_i),
    .write_valid_o (write_valid_o),
    .write_ready_i (write_ready_i),
    .write_num_o   (write_num_o),
    .write_data_o  (write_data_o),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           num;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] D0 = 32'hd0d0_0000, D1 = 32'hd1d1_1111,
                          D2 = 32'hd2d2_2222, D3 = 32'hd3d3_3333;
  localparam logic [31:0] E0 = 32'he000_0001, E1 = 32'he111_0002,
                          E2 = 32'he222_0003, E3 = 32'he333_0004;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference compaction: the k-th output slot takes the k-th set lane.
  function automatic exp_t model(input logic [L-1:0] m, input logic [127:0] d);
    exp_t e;
    int   seen;
    e.num  = 0;
    e.data = '0;
    for (int k = 0; k < L; k++) begin
      seen = 0;
      for (int i = 0; i < L; i++) begin
        if (m[i]) begin
          if (seen == k) e.data[k*DW +: DW] = d[i*DW +: DW];
          seen++;
        end
      end
      if (k < seen) e.num = k + 1;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [L-1:0] m, input logic [127:0] d,
                      input int enum_, input logic [127:0] edata);
    int   guard;
    exp_t e;
    guard      = 0;
    in_valid_i = 1'b1;
    in_mask_i  = m;
    in_data_i  = d;
    while (!in_ready_o && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready_o stuck at %0b, want 1", in_ready_o);
    end
    if (m != '0) begin
      e.num = enum_; e.data = edata;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: sample at negedge, after stimulus has settled and before the next edge.
  logic         stall_prev = 1'b0;
  logic [NW-1:0] num_prev;
  logic [127:0]  data_prev;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush_i) begin
      if (stall_prev) begin
        chk("stall_valid", {127'b0, write_valid_o}, 128'd1);
        chk("stall_num",   {125'b0, write_num_o}, {125'b0, num_prev});
        chk("stall_data",  write_data_o, data_prev);
      end
      if (write_valid_o && write_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: num=%0d data=%0h, want no write", write_num_o, write_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("write_num",  {125'b0, write_num_o}, 128'(e.num));
          chk("write_data", write_data_o, e.data);
        end
      end
    end
    stall_prev = rst_n && !flush_i && write_valid_o && !write_ready_i;
    num_prev   = write_num_o;
    data_prev  = write_data_o;
  end

  initial begin
    exp_t e;
    logic [L-1:0] m;
    logic [127:0] d;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; in_mask_i = 4'hf;
    in_data_i = {4{32'hbad0_bad0}}; write_ready_i = 1'b1;
    idle(3);
    chk("rst_in_ready",    {127'b0, in_ready_o}, 128'd1);
    chk("rst_write_valid", {127'b0, write_valid_o}, 128'd0);
    chk("rst_write_num",   {125'b0, write_num_o}, 128'd0);
    chk("rst_write_data",  write_data_o, 128'd0);
    chk("rst_pending",     {124'b0, pending_o}, 128'd0);
    in_valid_i = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // Sparse mask: slots {D3,D1}, one cycle latency.
    send(4'b1010, {D3, D2, D1, D0}, 2, {32'h0, 32'h0, D3, D1});
    chk("lat_valid",   {127'b0, write_valid_o}, 128'd1);
    chk("lat_num",     {125'b0, write_num_o}, 128'd2);
    chk("lat_pending", {124'b0, pending_o}, 128'd2);
    idle(1);
    chk("drained_valid", {127'b0, write_valid_o}, 128'd0);

    // All-zero mask is consumed silently.
    send(4'b0000, {D3, D2, D1, D0}, 0, '0);
    chk("zero_valid",   {127'b0, write_valid_o}, 128'd0);
    chk("zero_pending", {124'b0, pending_o}, 128'd0);

    // Backpressure fills OUT then SKID.
    write_ready_i = 1'b0;
    send(4'b1111, {D3, D2, D1, D0}, 4, {D3, D2, D1, D0});
    chk("one_pending",  {124'b0, pending_o}, 128'd4);
    chk("one_in_ready", {127'b0, in_ready_o}, 128'd1);
    send(4'b0001, {D3, D2, D1, D0}, 1, {32'h0, 32'h0, 32'h0, D0});
    chk("two_in_ready", {127'b0, in_ready_o}, 128'd0);
    chk("two_pending",  {124'b0, pending_o}, 128'd5);
    chk("two_num",      {125'b0, write_num_o}, 128'd4);
    write_ready_i = 1'b1;
    idle(1);
    chk("skid_mv_num",      {125'b0, write_num_o}, 128'd1);
    chk("skid_mv_in_ready", {127'b0, in_ready_o}, 128'd1);
    chk("skid_mv_pending",  {124'b0, pending_o}, 128'd1);
    idle(1);
    chk("bp_empty_valid", {127'b0, write_valid_o}, 128'd0);

    // Back-to-back at full throughput.
    send(4'b0110, {E3, E2, E1, E0}, 2, {32'h0, 32'h0, E2, E1});
    chk("b2b0_num", {125'b0, write_num_o}, 128'd2);
    send(4'b1001, {E3, E2, E1, E0}, 2, {32'h0, 32'h0, E3, E0});
    chk("b2b1_num", {125'b0, write_num_o}, 128'd2);
    send(4'b1000, {E3, E2, E1, E0}, 1, {32'h0, 32'h0, 32'h0, E3});
    chk("b2b2_num", {125'b0, write_num_o}, 128'd1);
    idle(1);

    // Flush from TWO with a concurrent input packet.
    write_ready_i = 1'b0;
    send(4'b0011, {E3, E2, E1, E0}, 2, {32'h0, 32'h0, E1, E0});
    send(4'b1100, {E3, E2, E1, E0}, 2, {32'h0, 32'h0, E3, E2});
    chk("pre_flush_in_ready", {127'b0, in_ready_o}, 128'd0);
    flush_i = 1'b1; in_valid_i = 1'b1; in_mask_i = 4'b1111; in_data_i = {D3, D2, D1, D0};
    write_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    exp_q.delete();
    chk("flush_valid",    {127'b0, write_valid_o}, 128'd0);
    chk("flush_pending",  {124'b0, pending_o}, 128'd0);
    chk("flush_in_ready", {127'b0, in_ready_o}, 128'd1);
    idle(3);
    chk("post_flush_valid", {127'b0, write_valid_o}, 128'd0);

    // Random stream with random backpressure.
    for (int n = 0; n < 400; n++) begin
      write_ready_i = ($urandom_range(0, 2) != 0);
      in_valid_i    = ($urandom_range(0, 3) != 0);
      m = 4'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      in_mask_i = m;
      in_data_i = d;
      if (in_valid_i && in_ready_o && m != '0) begin
        e = model(m, d);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    write_ready_i = 1'b1;
    idle(5);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
    chk("final_pending",     {124'b0, pending_o}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_port_fifo_packer.md
# multi_port_fifo_packer

Producer-side front end for the multi-port FIFO. It accepts one packet per cycle from an upstream stage. Each packet has an arbitrary, possibly sparse, lane-valid mask. The packer compacts the valid lanes to a contiguous run starting at lane 0 and presents them as a registered write_valid/write_num/write_data request, which is the form the FIFO's write side requires. A two-entry skid stage keeps in_ready_o free of any combinational path from write_ready_i.

## Interface
- LANES, 4, lanes per packet; equals the FIFO's WPORTS_NUM.
- DATA_WIDTH, 32, bits per lane.
- NUM_WIDTH, $clog2(LANES+1), localparam; width of write_num_o and pending_o.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous discard of all held packets.
- in_valid_i  in  1  upstream packet valid.
- in_ready_o  out  1  packer can accept a packet this cycle.
- in_mask_i  in  LANES  per-lane valid; any pattern allowed, including all-zero.
- in_data_i  in  LANES×DATA_WIDTH  lane payloads.
- write_valid_o  out  1  FIFO write request.
- write_ready_i  in  1  FIFO write_ready.
- write_num_o  out  NUM_WIDTH  count of valid lanes, 1..LANES whenever write_valid_o=1.
- write_data_o  out  LANES×DATA_WIDTH  compacted payload; slots ≥ write_num_o are zero.
- pending_o  out  NUM_WIDTH+1  total elements held across both stages.

## Operation
- Compaction:
  - Output slot k takes in_data_i[i] for the unique i with in_mask_i[i]=1 and popcount(in_mask_i[i-1:0])=k.
  - num = popcount(in_mask_i), computed at NUM_WIDTH bits with no overflow.
  - Lane order is preserved.
- Accept occurs when in_valid_i & in_ready_o & rst_n & ~flush_i.
  - An accepted packet with mask = 0 is consumed and dropped. It never produces write_valid_o.
- Storage: output register OUT (valid, num, data) and skid register SKID (valid, num, data).
- States, encoded by {SKID.valid, OUT.valid}:
  - EMPTY: 00.
  - ONE: 01.
  - TWO: 11.
  - 10 is illegal.
- Transitions. "drain" = write_valid_o & write_ready_i. "acc" = accept with a nonzero mask.
  - EMPTY: on acc, load OUT → ONE.
  - ONE, drain & acc: load OUT → ONE.
  - ONE, drain & ~acc: → EMPTY.
  - ONE, ~drain & acc: load SKID → TWO.
  - ONE, neither: hold.
  - TWO, drain: OUT ← SKID → ONE. No accept is possible in TWO, since in_ready_o=0.
  - TWO, ~drain: hold.
- in_ready_o = ~SKID.valid. It is a pure register decode.
- write_valid_o = OUT.valid. write_num_o = OUT.num. write_data_o = OUT.data.
- While write_valid_o=1 and write_ready_i=0, OUT is held stable (no data or num change).
- pending_o = (OUT.valid ? OUT.num : 0) + (SKID.valid ? SKID.num : 0).
- flush_i: next state is EMPTY with all registers zeroed. The same-cycle input is dropped and the same-cycle FIFO handshake is ignored. flush_i has priority over accept and drain.

## Timing
- Reset (rst_n=0 at a clk edge): all registers zero.
  - Outputs: write_valid_o=0, write_num_o=0, write_data_o=0, pending_o=0, in_ready_o=1.
  - Inputs are ignored while rst_n=0.
- Latency: a packet accepted at edge N appears on write_valid_o in the cycle after edge N, provided OUT is free or draining.
- Throughput: one packet per cycle sustained while write_ready_i=1.
- Backpressure: in_ready_o falls one cycle after the accept that fills SKID.
- Reset or flush mid-operation discards held packets. Elements already handshaken into the FIFO are unaffected.

## Structure
- The shared package holds the lane mask type (logic [LANES-1:0]) and the helper function popcount.
- One sub-module, lane_compactor: purely combinational; in mask/data → out num/data. It is instantiated once, on the input side, so both OUT and SKID store compacted data.
- The packer top holds the two registers, the state decode and pending_o.

## Test plan
- Reset → in_ready_o=1, write_valid_o=0, pending_o=0. Then mask 4'b1010, data {D3,D2,D1,D0}, write_ready_i=1 → next cycle write_valid_o=1, write_num_o=2, write_data_o={0,0,D3,D1}.
- Mask 4'b0000 accepted → no write_valid_o pulse, pending_o stays 0.
- write_ready_i=0; accept masks 4'b1111 then 4'b0001 → in_ready_o=0 and pending_o=5. Raise write_ready_i → OUT drains num 4 then num 1 on consecutive cycles, and in_ready_o returns to 1.
- Back-to-back masks 4'b0110, 4'b1001, 4'b1000 with write_ready_i=1 → three consecutive writes, num 2, 2, 1, in order.
- In state TWO, flush_i=1 together with in_valid_i=1 → next cycle write_valid_o=0, pending_o=0, in_ready_o=1, and the flush-cycle packet never appears.
- Random masks and random write_ready_i → a scoreboard checks that the FIFO-side element stream equals the masked input stream in order, and that write_data_o never changes while stalled.
